// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared types and constants for the dual-issue fetch sequencer.
// Holds the sequencer state encoding, the STOP opcode default and the layout
// of one decoupling-queue entry.
package fetch_seq_pkg;

    // PC width carried in each queue entry; the sequencer's PC_W defaults to it.
    localparam int FETCH_PC_W = 11;

    // Opcode (instr[31:21]) that halts fetch.
    localparam logic [10:0] STOP_OPC_DEF = 11'h000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // One fetched pair as seen by decode.
    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           instr1;
        logic [31:0]           instr2;
        logic [1:0]            slot_valid;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t between fetch and decode.
// Registered storage only (no bypass); push and pop may coincide when full.
// Synchronous clear drops every entry.
module fetch_queue
    import fetch_seq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Pointer and occupancy bookkeeping; reset and clear both empty the queue.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; validity comes from r_count, so stale data is never exposed as valid.
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: dual-issue fetch stage sequencer.
// Decides each cycle whether fetch advances, redirects fetch on taken branches,
// captures each fetched pair into a decoupling queue and halts on STOP.
// Optional build macro FETCH_SEQ_PERF_EN adds saturating stall/redirect counters.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int          PC_W      = FETCH_PC_W,
    parameter int          BUF_DEPTH = 2,
    parameter logic [10:0] STOP_OPC  = STOP_OPC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     if_instr1,
    input  logic [31:0]     if_instr2,
    output logic            enable_pc,
    output logic            branch_flag,
    output logic [PC_W-1:0] branch_target,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr1,
    output logic [31:0]     dec_instr2,
    output logic [PC_W-1:0] dec_pc,
    output logic [1:0]      dec_slot_valid,
    output logic            halted
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [15:0]     perf_stall_cnt,
    output logic [15:0]     perf_redirect_cnt
`endif
);

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_redirect;   // next pushed pair is the first after a redirect

    logic            w_br_accept;
    logic            w_dec_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_stop;
    logic            w_show;
    logic            w_q_full;
    logic            w_q_empty;
    logic [1:0]      w_slot_valid;
    fetch_entry_t    w_new;
    fetch_entry_t    w_head;

    // Reset gates every combinational decision so outputs read 0 during reset.
    assign w_br_accept  = !reset && br_taken && (r_state != ST_HALT);
    assign w_dec_valid  = !reset && !w_q_empty && !w_br_accept;
    assign w_pop        = w_dec_valid && dec_ready;
    assign w_push       = !reset && (r_state == ST_RUN) && !w_br_accept
                          && (!w_q_full || w_pop);

    // A redirect to an odd word kills the even slot of the first pair.
    assign w_slot_valid = r_redirect ? {1'b1, ~r_pc[2]} : 2'b11;

    // STOP counts only in a live slot of a pair that is actually pushed.
    assign w_stop = w_push
                    && ((w_slot_valid[0] && (if_instr1[31:21] == STOP_OPC))
                        || (if_instr2[31:21] == STOP_OPC));

    assign w_new = '{pc: r_pc, instr1: if_instr1, instr2: if_instr2,
                     slot_valid: w_slot_valid};

    fetch_queue #(
        .DEPTH (BUF_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_br_accept),
        .i_data  (w_new),
        .o_head  (w_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    // FSM, shadow PC (mirrors the fetch PC) and redirect marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_redirect <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_RUN;
                ST_RUN:  if (w_stop) r_state <= ST_HALT;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase

            if (w_br_accept) begin
                r_pc       <= br_pc;
                r_redirect <= 1'b1;
            end else if (w_push) begin
                r_pc       <= r_pc + PC_W'(8);
                r_redirect <= 1'b0;
            end
        end
    end

    assign w_show         = !reset && !w_q_empty;
    assign enable_pc      = w_push;
    assign branch_flag    = w_br_accept;
    assign branch_target  = w_br_accept ? br_pc : '0;
    assign dec_valid      = w_dec_valid;
    assign dec_instr1     = w_show ? w_head.instr1     : '0;
    assign dec_instr2     = w_show ? w_head.instr2     : '0;
    assign dec_pc         = w_show ? w_head.pc         : '0;
    assign dec_slot_valid = w_show ? w_head.slot_valid : '0;
    assign halted         = !reset && (r_state == ST_HALT);

`ifdef FETCH_SEQ_PERF_EN
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_redirect;

    // Saturating counters: RUN cycles with no fetch progress, and accepted branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall    <= '0;
            r_perf_redirect <= '0;
        end else begin
            if ((r_state == ST_RUN) && !w_push && !br_taken
                && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
            if (w_br_accept && (r_perf_redirect != 16'hFFFF)) begin
                r_perf_redirect <= r_perf_redirect + 16'd1;
            end
        end
    end

    assign perf_stall_cnt    = reset ? '0 : r_perf_stall;
    assign perf_redirect_cnt = reset ? '0 : r_perf_redirect;
`endif

`ifndef SYNTHESIS
    // Branch destinations must be word aligned.
    a_br_pc_aligned : assert property (@(posedge clk) disable iff (reset)
        br_taken |-> (br_pc[1:0] == 2'b00));
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus randomized traffic, checked
// cycle by cycle against a queue-based behavioural model of the fetch stage.
module tb_fetch_sequencer;

    localparam int          PC_W  = 11;
    localparam int          DEPTH = 2;
    localparam logic [10:0] STOP  = 11'h000;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     i1;
        logic [31:0]     i2;
        logic [1:0]      sv;
    } m_entry_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     if_instr1, if_instr2;
    logic            enable_pc, branch_flag;
    logic [PC_W-1:0] branch_target;
    logic            br_taken;
    logic [PC_W-1:0] br_pc;
    logic            dec_valid, dec_ready;
    logic [31:0]     dec_instr1, dec_instr2;
    logic [PC_W-1:0] dec_pc;
    logic [1:0]      dec_slot_valid;
    logic            halted;
`ifdef FETCH_SEQ_PERF_EN
    logic [15:0]     perf_stall_cnt, perf_redirect_cnt;
`endif

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .if_instr1      (if_instr1),
        .if_instr2      (if_instr2),
        .enable_pc      (enable_pc),
        .branch_flag    (branch_flag),
        .branch_target  (branch_target),
        .br_taken       (br_taken),
        .br_pc          (br_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr1     (dec_instr1),
        .dec_instr2     (dec_instr2),
        .dec_pc         (dec_pc),
        .dec_slot_valid (dec_slot_valid),
        .halted         (halted)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    // Instruction memory behind the fetch unit (word addressed).
    logic [31:0] mem [512];

    // Behavioural model: 0 = idle, 1 = running, 2 = halted.
    int              m_state;
    logic [PC_W-1:0] m_pc;
    bit              m_redir;
    m_entry_t        m_q[$];
    int              m_stall_cnt;
    int              m_redir_cnt;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [PC_W-1:0] a);
        return mem[a[PC_W-1:2]];
    endfunction

    function automatic logic [31:0] nonstop_word();
        return $urandom() | 32'h8000_0000;
    endfunction

    function automatic logic [31:0] stop_word();
        return {STOP, 21'($urandom())};
    endfunction

    // One clock: drive inputs just after the edge, check mid-cycle, advance model.
    task automatic cycle(input bit rst, input bit br, input logic [PC_W-1:0] bpc, input bit rdy);
        bit       acc, vld, pop, push, stp;
        m_entry_t e;
        reset     = rst;
        br_taken  = br;
        br_pc     = bpc;
        dec_ready = rdy;
        if_instr1 = rd(m_pc);
        if_instr2 = rd(m_pc + 11'd4);
        #3;
        if (rst) begin
            check("rst_enable_pc", enable_pc, 0);
            check("rst_branch_flag", branch_flag, 0);
            check("rst_branch_target", branch_target, 0);
            check("rst_dec_valid", dec_valid, 0);
            check("rst_dec_instr1", dec_instr1, 0);
            check("rst_dec_instr2", dec_instr2, 0);
            check("rst_dec_pc", dec_pc, 0);
            check("rst_slot_valid", dec_slot_valid, 0);
            check("rst_halted", halted, 0);
`ifdef FETCH_SEQ_PERF_EN
            check("rst_perf_stall", perf_stall_cnt, 0);
            check("rst_perf_redirect", perf_redirect_cnt, 0);
`endif
            m_state = 0; m_pc = '0; m_redir = 0; m_q.delete();
            m_stall_cnt = 0; m_redir_cnt = 0;
        end else begin
            acc  = br && (m_state != 2);
            vld  = (m_q.size() > 0) && !acc;
            pop  = vld && rdy;
            push = (m_state == 1) && !acc && ((m_q.size() < DEPTH) || pop);
            check("enable_pc", enable_pc, push);
            check("branch_flag", branch_flag, acc);
            check("branch_target", branch_target, acc ? bpc : 11'd0);
            check("dec_valid", dec_valid, vld);
            check("halted", halted, m_state == 2);
            if (vld) begin
                check("dec_pc", dec_pc, m_q[0].pc);
                check("dec_instr1", dec_instr1, m_q[0].i1);
                check("dec_instr2", dec_instr2, m_q[0].i2);
                check("dec_slot_valid", dec_slot_valid, m_q[0].sv);
            end
`ifdef FETCH_SEQ_PERF_EN
            check("perf_stall", perf_stall_cnt, m_stall_cnt);
            check("perf_redirect", perf_redirect_cnt, m_redir_cnt);
`endif
            if (m_state == 1 && !push && !br && m_stall_cnt < 65535) m_stall_cnt++;
            if (acc && m_redir_cnt < 65535) m_redir_cnt++;
            stp = 0;
            if (acc) begin
                m_q.delete();
                m_pc    = bpc;
                m_redir = 1;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    e.pc = m_pc;
                    e.i1 = if_instr1;
                    e.i2 = if_instr2;
                    e.sv = m_redir ? {1'b1, ~m_pc[2]} : 2'b11;
                    stp  = (e.sv[0] && (e.i1[31:21] == STOP)) || (e.i2[31:21] == STOP);
                    m_q.push_back(e);
                    m_pc    = m_pc + 11'd8;
                    m_redir = 0;
                end
            end
            if (m_state == 0) m_state = 1;
            else if (m_state == 1 && stp) m_state = 2;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; br_taken = 1'b0; br_pc = '0; dec_ready = 1'b0;
        if_instr1 = '0; if_instr2 = '0;
        m_state = 0; m_pc = '0; m_redir = 0; m_stall_cnt = 0; m_redir_cnt = 0;
        for (int i = 0; i < 512; i++) mem[i] = nonstop_word();
        @(posedge clk);
        #1;

        // Reset beats a simultaneous branch.
        cycle(1, 1, 11'h040, 1);
        cycle(1, 0, 11'h000, 1);

        // Streaming: one idle cycle, then pairs 0,8,16,24...
        for (int i = 0; i < 7; i++) cycle(0, 0, 11'h000, 1);

        // Back-pressure from decode, then release.
        cycle(1, 0, 11'h000, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 11'h000, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 11'h000, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 11'h000, 1);

        // Branch to 0x40 while the queue holds two entries.
        for (int i = 0; i < 3; i++) cycle(0, 0, 11'h000, 0);
        cycle(0, 1, 11'h040, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 11'h000, 1);

        // Branch to an odd word: even slot of the first pair is killed.
        cycle(0, 1, 11'h044, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 11'h000, 1);

        // STOP in the odd slot of pair 0x18.
        mem[7] = stop_word();
        cycle(1, 0, 11'h000, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 11'h000, 1);
        check("stop_halted", halted, 1'b1);
        cycle(0, 1, 11'h080, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 11'h000, 1);
        cycle(1, 0, 11'h000, 1);
        cycle(0, 0, 11'h000, 1);
        check("reset_pc_restart", enable_pc, 1'b1);
        mem[7] = nonstop_word();

        // Branch coincident with a STOP pair and a full-queue pop.
        mem[4] = stop_word();
        cycle(1, 0, 11'h000, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 11'h000, 0);
        cycle(0, 1, 11'h080, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 11'h000, 1);
        check("branch_beats_stop", halted, 1'b0);
        mem[4] = nonstop_word();

        // Randomized traffic with occasional STOP words and resets.
        for (int i = 0; i < 512; i++)
            mem[i] = ($urandom_range(0, 63) == 0) ? stop_word() : nonstop_word();
        cycle(1, 0, 11'h000, 1);
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0,
                  {9'($urandom_range(0, 511)), 2'b00},
                  $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
